c17_response_checker: RTL
=========================

Name: c17_response_checker

Overview:
- Downstream observation stage for the C17 benchmark netlist in fault-injection and reliability campaigns.
- Each cycle it can accept one pattern: the golden (fault-free) C17 outputs and the outputs of the fault-injected copy.
- It counts patterns, mismatching patterns and mismatching bits, and records the index of the first failing pattern.
- It compacts the faulty outputs into a MISR signature and reports completion after a programmed number of patterns.

Parameters:
N_OUT, 2, number of compared output bits (G6gat and G7gat).
CNT_W, 16, width of the pattern counter, the error counters and num_patterns.
SIG_W, 16, MISR width; must be at least N_OUT.
POLY, 16'h1021, MISR feedback polynomial taps, SIG_W bits wide.
SIG_SEED, 16'h0000, MISR value loaded on reset and on start.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RST  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse that begins a campaign; honoured only in IDLE or DONE.
num_patterns  input  CNT_W  number of patterns in the campaign; sampled on start.
in_valid  input  1  golden and faulty carry a valid pattern.
in_ready  output  1  checker accepts a pattern this cycle.
golden  input  N_OUT  fault-free outputs, bit0=G6gat, bit1=G7gat.
faulty  input  N_OUT  fault-injected outputs, same bit order.
busy  output  1  high in RUN.
done  output  1  high in DONE.
pat_count  output  CNT_W  patterns accepted in this campaign.
err_count  output  CNT_W  accepted patterns with any mismatch; saturating.
bit_err_count  output  CNT_W  total mismatching bits; saturating.
first_fail_valid  output  1  at least one mismatch seen in this campaign.
first_fail_idx  output  CNT_W  value of pat_count when the first mismatch was accepted (0-based).
signature  output  SIG_W  MISR state.

Behaviour:
- Reset (RST=1 at an edge): go to IDLE and clear all counters, first_fail_valid and first_fail_idx. signature=SIG_SEED. in_ready, busy and done are 0. Reset in any state, including mid-RUN, aborts the campaign with no further output.
- States:
  - IDLE: in_ready=0. start with num_patterns!=0 goes to RUN. start with num_patterns=0 goes directly to DONE.
  - RUN: in_ready=1 and busy=1. Go to DONE on the edge that accepts pattern number target-1, so pat_count==target on entry to DONE. start is ignored.
  - DONE: in_ready=0 and done=1. All results hold until the next start, which behaves as it does in IDLE.
- On an honoured start:
  - Clear pat_count, err_count, bit_err_count and first_fail_*.
  - Load signature=SIG_SEED.
  - Latch target=num_patterns. Later changes to num_patterns have no effect.
- Accept = in_valid & in_ready. Only an accepted pattern changes state. in_valid in IDLE or DONE is ignored and dropped. There is no back-pressure in RUN.
- On accept, with m = golden ^ faulty:
  - pat_count increments by 1.
  - If m!=0: err_count increments, saturating at all-ones. If first_fail_valid was 0, first_fail_idx takes the pre-increment pat_count and first_fail_valid is set.
  - bit_err_count increments by popcount(m), saturating at all-ones.
  - signature = ({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero_extend(faulty).
- All outputs are registered. Results are visible the cycle after the accepting edge. The accept latency is 0 cycles, since in_ready is combinational from state only.

Test Plan:
1. Reset, then start with num_patterns=4 and four accepts where golden==faulty=2'b00 -> done=1 one cycle after the 4th accept; pat_count=4, err_count=0, bit_err_count=0, first_fail_valid=0, signature=0x0000.
2. SIG_SEED=0, num_patterns=2, faulty=2'b11 then 2'b01, golden=faulty -> signature=0x0003 after the first accept and 0x0007 after the second.
3. num_patterns=5, mismatch only on pattern index 2 with golden=2'b10 and faulty=2'b01 -> err_count=1, bit_err_count=2, first_fail_idx=2, first_fail_valid=1.
4. CNT_W=4, num_patterns=15, every pattern has golden=2'b00 and faulty=2'b11 -> err_count=15, bit_err_count saturates at 15, done=1.
5. start with num_patterns=0 -> DONE next cycle; in_ready never asserts and all counts are 0. in_valid pulses in IDLE and DONE change nothing.
6. RST asserted after 3 of 8 patterns -> all outputs return to their reset values the next cycle, with state IDLE. A second start mid-RUN is ignored.

Source files
------------

// File: rtl/c17_response_checker.sv
// Response checker for the C17 netlist: compares golden vs fault-injected outputs per pattern,
// keeps pattern/error/bit-error counts, first failing index and a MISR signature of the faulty outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, no patterns accepted
// ST_RUN   | campaign active, one pattern accepted per valid cycle
// ST_DONE  | target reached, results held until the next start
module c17_response_checker #(
    parameter int unsigned      N_OUT    = 2,
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_OUT-1:0] golden,
    input  logic [N_OUT-1:0] faulty,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   pat_count_q, pat_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_err_count_q, bit_err_count_d;
    logic               first_fail_valid_q, first_fail_valid_d;
    logic [CNT_W-1:0]   first_fail_idx_q, first_fail_idx_d;
    logic [SIG_W-1:0]   signature_q, signature_d;

    logic               accept;
    logic [N_OUT-1:0]   mismatch;
    logic [CNT_W:0]     bit_sum;
    logic [CNT_W-1:0]   pat_inc;

    always_comb begin
        state_d            = state_q;
        target_d           = target_q;
        pat_count_d        = pat_count_q;
        err_count_d        = err_count_q;
        bit_err_count_d    = bit_err_count_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_idx_d   = first_fail_idx_q;
        signature_d        = signature_q;

        accept   = in_valid && (state_q == ST_RUN);
        mismatch = golden ^ faulty;
        pat_inc  = pat_count_q + 1'b1;

        // One extra bit catches overflow; N_OUT is far below 2**CNT_W so it cannot wrap twice.
        bit_sum = {1'b0, bit_err_count_q};
        for (int i = 0; i < int'(N_OUT); i++) begin
            bit_sum = bit_sum + (CNT_W+1)'(mismatch[i]);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pat_count_d        = '0;
                    err_count_d        = '0;
                    bit_err_count_d    = '0;
                    first_fail_valid_d = 1'b0;
                    first_fail_idx_d   = '0;
                    signature_d        = SIG_SEED;
                    target_d           = num_patterns;
                    state_d            = (num_patterns == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    pat_count_d = pat_inc;
                    if (mismatch != '0) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!first_fail_valid_q) begin
                            first_fail_valid_d = 1'b1;
                            first_fail_idx_d   = pat_count_q;
                        end
                    end
                    bit_err_count_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                    signature_d = {signature_q[SIG_W-2:0], 1'b0}
                                ^ (signature_q[SIG_W-1] ? POLY : '0)
                                ^ SIG_W'(faulty);
                    if (pat_inc == target_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q            <= ST_IDLE;
            target_q           <= '0;
            pat_count_q        <= '0;
            err_count_q        <= '0;
            bit_err_count_q    <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_idx_q   <= '0;
            signature_q        <= SIG_SEED;
        end else begin
            state_q            <= state_d;
            target_q           <= target_d;
            pat_count_q        <= pat_count_d;
            err_count_q        <= err_count_d;
            bit_err_count_q    <= bit_err_count_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_idx_q   <= first_fail_idx_d;
            signature_q        <= signature_d;
        end
    end

    assign in_ready         = (state_q == ST_RUN);
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pat_count        = pat_count_q;
    assign err_count        = err_count_q;
    assign bit_err_count    = bit_err_count_q;
    assign first_fail_valid = first_fail_valid_q;
    assign first_fail_idx   = first_fail_idx_q;
    assign signature        = signature_q;

endmodule
